bus_mem_responder: RTL
======================

Name: bus_mem_responder

Overview:
- Responder (slave-side) endpoint for the req/ack/resp bus driven by the cross-bar master ports.
- Accepts read and write transactions, stores data in an internal word-addressed memory, and returns read data through the resp/rdata channel.
- Ack latency and response latency are programmable, so the cross-bar arbiters and response routing can be exercised against a realistic, back-pressuring target.

Parameters:
- AWIDTH, 32, address width.
- DWIDTH, 32, data width; must be a multiple of 8.
- MEM_DEPTH, 256, number of DWIDTH words in memory; power of 2.
- ACK_DELAY, 0, extra cycles between req sampled and ack (0..15).
- RESP_DELAY, 0, extra cycles between read queued and resp (0..15).
- RD_FIFO_DEPTH, 4, read responses that may be outstanding; power of 2, >=2.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  reset.
- s_req  in  1  transaction request; held with addr/cmd/wdata until ack.
- s_addr  in  AWIDTH  byte address.
- s_cmd  in  1  0 = read, 1 = write.
- s_wdata  in  DWIDTH  write data.
- s_ack  out  1  one-cycle accept pulse.
- s_rdata  out  DWIDTH  read data, valid only while s_resp = 1.
- s_resp  out  1  one-cycle read-response strobe.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset state: s_ack = 0, s_resp = 0, s_rdata = 0, FSM = IDLE, delay counters = 0, read FIFO empty, response engine idle.
- Memory contents are not reset.
- Reset asserted mid-operation aborts any in-progress ack and discards all queued read responses; nothing is emitted after reset.
- Word index = s_addr[ADDR_LSB +: log2(MEM_DEPTH)], with ADDR_LSB = log2(DWIDTH/8).
  - Low byte-offset bits are ignored.
  - Upper address bits are ignored; addresses alias modulo MEM_DEPTH words.
- Accept FSM, states IDLE, WAIT, ACK:
  - IDLE: if s_req = 1 and (s_cmd = 1 or FIFO not full), load cnt = ACK_DELAY and go to WAIT. Otherwise stay in IDLE; a read against a full FIFO is stalled, with no ack.
  - WAIT: if cnt = 0, go to ACK; else decrement cnt.
  - ACK: s_ack = 1 for this cycle only. Execute on the sampled bus: a write commits wdata at the end of the cycle; a read pushes mem[index] into the read FIFO at the end of the cycle. Next state is IDLE.
- Accept timing:
  - req first sampled high in IDLE at cycle t gives ack at cycle t+2+ACK_DELAY.
  - Minimum spacing between acks is 3+ACK_DELAY cycles.
  - Dropping req before ack is a protocol violation; the block still completes the ack using the bus values sampled in the ACK cycle.
- Read-after-write to the same address in back-to-back transactions returns the new data.
- Response engine, states RIDLE, RCOUNT, RSEND:
  - RIDLE: if FIFO not empty, load rcnt = RESP_DELAY and go to RCOUNT.
  - RCOUNT: if rcnt = 0, go to RSEND; else decrement rcnt.
  - RSEND: s_resp = 1 and s_rdata = FIFO head; pop; go to RIDLE.
- Response timing:
  - A read acked at cycle t gives resp at the earliest at t+3+RESP_DELAY.
  - Responses are spaced at least 3+RESP_DELAY cycles apart and return in acceptance order.
- FIFO push and pop in the same cycle are both performed; the count is unchanged.
- Full is evaluated on the registered count. A read sampled in IDLE while full stays stalled until a pop frees an entry.
- Writes never generate resp and are never blocked by FIFO occupancy.
- s_rdata returns to 0 in every cycle where s_resp = 0.
- Count and pointer widths are log2(RD_FIFO_DEPTH)+1 bits; pointers wrap modulo RD_FIFO_DEPTH.

Test Plan:
- Reset defaults, ACK_DELAY=0: after areset, write addr 0x10 data 0xDEADBEEF with req at cycle 0 -> ack pulse exactly at cycle 2, one cycle wide, no resp ever.
- Read-back: read 0x10 with ACK_DELAY=0, RESP_DELAY=0 -> ack 2 cycles after req, resp 3 cycles after ack, rdata = 0xDEADBEEF, rdata = 0 on all other cycles.
- Delays and alias, ACK_DELAY=3, RESP_DELAY=2: write 0x400 with 0x5A5A5A5A, MEM_DEPTH=256, so it aliases to word 0; read 0x0 -> ack at req+5, resp at ack+5, rdata = 0x5A5A5A5A.
- Backpressure, RD_FIFO_DEPTH=4, RESP_DELAY=15: five consecutive reads of addresses 0..4 -> four acks, fifth read stalled until first resp; after it, fifth ack follows; responses come in order.
- Push/pop collision: ack of a read in the same cycle as RSEND pop -> FIFO count unchanged, no data lost or duplicated.
- Reset mid-flight: three reads queued, areset high for 1 cycle -> no resp after reset, ack = 0, next write/read pair behaves as in the read-back scenario.

Source files
------------

// File: rtl/bus_mem_responder.sv
// Slave-side endpoint for the req/ack/resp bus: word memory, programmable ack latency,
// and a read-response FIFO drained by a delayed response engine.
module bus_mem_responder #(
    parameter int AWIDTH        = 32,
    parameter int DWIDTH        = 32,
    parameter int MEM_DEPTH     = 256,
    parameter int ACK_DELAY     = 0,
    parameter int RESP_DELAY    = 0,
    parameter int RD_FIFO_DEPTH = 4
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              s_req,
    input  logic [AWIDTH-1:0] s_addr,
    input  logic              s_cmd,
    input  logic [DWIDTH-1:0] s_wdata,
    output logic              s_ack,
    output logic [DWIDTH-1:0] s_rdata,
    output logic              s_resp
);
    localparam int ADDR_LSB = $clog2(DWIDTH / 8);
    localparam int IDX_W    = $clog2(MEM_DEPTH);
    localparam int PTR_W    = $clog2(RD_FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;
    localparam logic [1:0] RS_IDLE  = 2'd0;
    localparam logic [1:0] RS_COUNT = 2'd1;
    localparam logic [1:0] RS_SEND  = 2'd2;

    logic [DWIDTH-1:0] mem_q  [MEM_DEPTH];
    logic [DWIDTH-1:0] fifo_q [RD_FIFO_DEPTH];

    logic [1:0]       st_q, st_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       rs_q, rs_d;
    logic [3:0]       rcnt_q, rcnt_d;
    logic [CNT_W-1:0] wr_ptr_q, rd_ptr_q, fcnt_q, fcnt_d;

    logic [IDX_W-1:0] idx;
    logic             full, empty, push, pop, wr_en;
    logic             unused_addr;

    assign idx         = s_addr[ADDR_LSB +: IDX_W];
    assign unused_addr = ^s_addr;
    assign full        = (fcnt_q == CNT_W'(RD_FIFO_DEPTH));
    assign empty       = (fcnt_q == '0);
    // The transaction executes on whatever the bus holds during the ACK cycle.
    assign wr_en       = (st_q == ST_ACK) && s_cmd && !areset;
    assign push        = (st_q == ST_ACK) && !s_cmd;
    assign pop         = (rs_q == RS_SEND);

    assign s_ack   = (st_q == ST_ACK);
    assign s_resp  = (rs_q == RS_SEND);
    assign s_rdata = s_resp ? fifo_q[rd_ptr_q[PTR_W-1:0]] : '0;

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        case (st_q)
            ST_IDLE: begin
                if (s_req && (s_cmd || !full)) begin
                    st_d  = ST_WAIT;
                    cnt_d = 4'(ACK_DELAY);
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) st_d = ST_ACK;
                else               cnt_d = cnt_q - 4'd1;
            end
            ST_ACK:  st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rs_d   = rs_q;
        rcnt_d = rcnt_q;
        case (rs_q)
            RS_IDLE: begin
                if (!empty) begin
                    rs_d   = RS_COUNT;
                    rcnt_d = 4'(RESP_DELAY);
                end
            end
            RS_COUNT: begin
                if (rcnt_q == 4'd0) rs_d = RS_SEND;
                else                rcnt_d = rcnt_q - 4'd1;
            end
            RS_SEND: rs_d = RS_IDLE;
            default: rs_d = RS_IDLE;
        endcase
    end

    always_comb begin
        fcnt_d = fcnt_q;
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            st_q     <= ST_IDLE;
            cnt_q    <= '0;
            rs_q     <= RS_IDLE;
            rcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            rs_q   <= rs_d;
            rcnt_q <= rcnt_d;
            fcnt_q <= fcnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage arrays carry no reset; occupancy is tracked by the pointers above.
    always_ff @(posedge aclk) begin
        if (wr_en) mem_q[idx] <= s_wdata;
        if (push)  fifo_q[wr_ptr_q[PTR_W-1:0]] <= mem_q[idx];
    end
endmodule
